clk_divider: RTL and testbench
==============================

CLK_DIVIDER -- requirements
Module: clk_divider

Interface
REQ-001 Parameter SLOW, default 27, divider exponent; legal range 0..30; the slow clock period SHALL be 2^(SLOW+1) clk cycles.
REQ-002 Parameter RST_HOLD, default 2, number of slow_clk falling edges to hold slow_resetn low after reset release; legal range 1..255.
REQ-003 Reset resetn, asynchronous, active-low; clock clk.
REQ-004 clk  input  1  fast reference clock; all state is clocked on its rising edge.
REQ-005 resetn  input  1  asynchronous active-low reset of all state.
REQ-006 slow_clk  output  1  divided clock, 50% duty cycle, driven directly from one register bit.
REQ-007 slow_resetn  output  1  active-low reset for the slow domain; asserts asynchronously and deasserts synchronously.
REQ-008 rise_pulse  output  1  high for exactly one clk cycle, the cycle immediately before a slow_clk rising edge.
REQ-009 fall_pulse  output  1  high for exactly one clk cycle, the cycle immediately before a slow_clk falling edge.
REQ-010 count  output  SLOW+1  current divider counter value.

Function
REQ-011 Counter cnt is SLOW+1 bits wide; it increments by 1 on every clk rising edge while resetn=1 and wraps from all-ones to 0.
REQ-012 slow_clk SHALL equal cnt[SLOW]: low for cnt 0..2^SLOW-1 and high for cnt 2^SLOW..2^(SLOW+1)-1.
REQ-013 slow_clk SHALL have no combinational path from any input and SHALL be glitch-free.
REQ-014 count SHALL equal cnt.
REQ-015 rise_pulse = (cnt == 2^SLOW-1) AND sync2; fall_pulse = (cnt == all-ones) AND sync2.
REQ-016 Reset synchronizer: two flops, sync1 and sync2, both cleared asynchronously by resetn; sync1 loads 1 and sync2 loads sync1 on each clk edge.
REQ-017 Hold counter hc (8 bits) clears asynchronously on reset and increments on each clk edge where fall_pulse=1 and hc < RST_HOLD.
REQ-018 slow_resetn is a register; it sets to 1 on the clk edge where fall_pulse=1 and hc == RST_HOLD-1, so deassertion always coincides with a slow_clk falling edge.
REQ-019 Once set, slow_resetn SHALL stay 1 until resetn is next asserted.
REQ-020 Consequence of REQ-016..REQ-018: both pulses are 0 while sync2=0, so any counter wrap before sync2=1 is not counted toward RST_HOLD.
REQ-021 SLOW=0 case: slow_clk toggles every clk edge, rise_pulse is high on even cnt and fall_pulse on odd cnt (both still gated by sync2).
REQ-022 Counter wrap needs no special handling; the counter runs free indefinitely.

Reset
REQ-023 When resetn=0, the following SHALL take their reset values immediately, independent of clk: cnt=0, slow_clk=0, sync1=0, sync2=0, hc=0, slow_resetn=0, rise_pulse=0, fall_pulse=0.
REQ-024 When resetn is asserted mid-operation, including while slow_clk=1, slow_clk SHALL drop to 0 at once.
REQ-025 After reset is released mid-operation, the full sequence SHALL restart from cnt=0.
REQ-026 The counter restarts on the first clk edge after resetn rises.

Verification
REQ-027 Reset release, SLOW=2, RST_HOLD=2, resetn rises before clk edge 1 -> after edge k, count=k mod 8; slow_clk is high after edges 4..7, 12..15, ...
REQ-028 Same setup -> sync2=1 after edge 2; the slow_clk falls counted by hc are at edges 8 and 16; slow_resetn goes 1 exactly after edge 16 and stays 1.
REQ-029 Same setup, pulses -> rise_pulse=1 only in the cycles where count=3; fall_pulse=1 only in the cycles where count=7.
REQ-030 Mid-run reset: assert resetn while count=6 (slow_clk=1) -> slow_clk, slow_resetn and count go to 0 without a clk edge; after release, the REQ-028 timing repeats.
REQ-031 SLOW=0, RST_HOLD=1 -> slow_clk toggles every clk edge; slow_resetn rises on the first fall_pulse edge after sync2=1, i.e. after clk edge 4.
REQ-032 Long run, SLOW=4 for 1000 clk cycles -> slow_clk period is 32 cycles with exactly 16 high; one rise_pulse and one fall_pulse occur per slow period.

Source files
------------

// File: rtl/clk_divider.sv
// ----------------------------------------------------------------------------
// clk_divider
//
// Divides the fast reference clock by 2^(SLOW+1) using a free-running binary
// counter. The counter's top bit is the slow clock, so slow_clk comes straight
// from a flop and cannot glitch. The block also produces a reset for the slow
// domain. That reset asserts asynchronously with resetn. It releases only on
// a slow_clk falling edge, after RST_HOLD qualified falling edges have
// elapsed.
//
// Parameters
//   SLOW      divider exponent (0..30); slow period = 2^(SLOW+1) clk cycles
//   RST_HOLD  qualified slow_clk falling edges to hold slow_resetn low (1..255)
//
// Ports
//   clk          in   fast reference clock; all state on its rising edge
//   resetn       in   asynchronous active-low reset of all state
//   slow_clk     out  divided clock, 50% duty, equal to counter bit SLOW
//   slow_resetn  out  slow-domain reset; async assert, sync deassert
//   rise_pulse   out  one clk cycle wide, the cycle before slow_clk rises
//   fall_pulse   out  one clk cycle wide, the cycle before slow_clk falls
//   count        out  current divider counter value (SLOW+1 bits)
// ----------------------------------------------------------------------------
module clk_divider #(
  parameter int SLOW     = 27,
  parameter int RST_HOLD = 2
) (
  input  logic          clk,
  input  logic          resetn,
  output logic          slow_clk,
  output logic          slow_resetn,
  output logic          rise_pulse,
  output logic          fall_pulse,
  output logic [SLOW:0] count
);

  // Out-of-range parameters would silently produce a nonsensical divider or
  // a hold count that never matches, so reject them at elaboration.
  if (SLOW < 0 || SLOW > 30) begin : g_bad_slow
    $error("clk_divider: SLOW=%0d outside 0..30", SLOW);
  end
  if (RST_HOLD < 1 || RST_HOLD > 255) begin : g_bad_hold
    $error("clk_divider: RST_HOLD=%0d outside 1..255", RST_HOLD);
  end

  // Counter values one cycle before each slow_clk edge. CNT_RISE is the
  // all-ones pattern with the top bit clear. For SLOW=0 it is 0, so the
  // pulses alternate on every cycle.
  localparam logic [SLOW:0] CNT_MAX   = '1;
  localparam logic [SLOW:0] CNT_RISE  = CNT_MAX >> 1;
  localparam logic [7:0]    HOLD_MAX  = 8'(RST_HOLD);
  localparam logic [7:0]    HOLD_LAST = 8'(RST_HOLD - 1);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [SLOW:0] cnt_q,   cnt_d;
  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic [7:0]    hc_q,    hc_d;
  logic          srn_q,   srn_d;

  logic          rise_hit;
  logic          fall_hit;

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    cnt_d    = cnt_q + 1'b1;  // wraps from all-ones to 0 by width
    sync1_d  = 1'b1;
    sync2_d  = sync1_q;
    hc_d     = hc_q;
    srn_d    = srn_q;

    // The pulses are gated by the synchronized reset. Counter wraps that
    // happen while the synchronizer is still filling produce no pulse and
    // do not count toward the hold.
    rise_hit = sync2_q && (cnt_q == CNT_RISE);
    fall_hit = sync2_q && (cnt_q == CNT_MAX);

    // The hold counter saturates at RST_HOLD. After saturation, further
    // falling edges leave it unchanged and it can never wrap back to
    // HOLD_LAST.
    if (fall_hit && (hc_q < HOLD_MAX)) begin
      hc_d = hc_q + 8'd1;
    end

    // Release happens on a fall_pulse edge. Deassertion therefore lands
    // exactly on a slow_clk falling edge. Once set, the flag stays set
    // until resetn.
    if (fall_hit && (hc_q == HOLD_LAST)) begin
      srn_d = 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q   <= '0;
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      hc_q    <= 8'd0;
      srn_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      hc_q    <= hc_d;
      srn_q   <= srn_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  // slow_clk is taken straight from a flop output, with no gating. The
  // async clear of cnt_q drops it the moment resetn falls.
  assign slow_clk    = cnt_q[SLOW];
  assign count       = cnt_q;
  assign slow_resetn = srn_q;
  assign rise_pulse  = rise_hit;
  assign fall_pulse  = fall_hit;

endmodule

// File: tb/tb_clk_divider.sv
// ----------------------------------------------------------------------------
// tb_clk_divider
//
// Runs three divider configurations side by side on a shared clock and reset:
//   inst 0: SLOW=2, RST_HOLD=2
//   inst 1: SLOW=0, RST_HOLD=1
//   inst 2: SLOW=4, RST_HOLD=3
// The driver counts clk edges since the last reset release (k). For each
// cycle it pushes the expected outputs into a scoreboard queue. Those values
// come from closed-form arithmetic on k. A monitor pops and compares each
// entry on the falling clock edge.
// ----------------------------------------------------------------------------
module tb_clk_divider;

  typedef struct {
    int          inst;
    logic [31:0] count;
    logic        slow_clk;
    logic        slow_resetn;
    logic        rise;
    logic        fall;
    bit          tally;
  } exp_t;

  logic       clk;
  logic       resetn;

  logic       slow_clk_a, slow_rstn_a, rise_a, fall_a;
  logic [2:0] count_a;
  logic       slow_clk_b, slow_rstn_b, rise_b, fall_b;
  logic [0:0] count_b;
  logic       slow_clk_c, slow_rstn_c, rise_c, fall_c;
  logic [4:0] count_c;

  clk_divider #(.SLOW(2), .RST_HOLD(2)) u_dut_a (
    .clk(clk), .resetn(resetn), .slow_clk(slow_clk_a), .slow_resetn(slow_rstn_a),
    .rise_pulse(rise_a), .fall_pulse(fall_a), .count(count_a)
  );

  clk_divider #(.SLOW(0), .RST_HOLD(1)) u_dut_b (
    .clk(clk), .resetn(resetn), .slow_clk(slow_clk_b), .slow_resetn(slow_rstn_b),
    .rise_pulse(rise_b), .fall_pulse(fall_b), .count(count_b)
  );

  clk_divider #(.SLOW(4), .RST_HOLD(3)) u_dut_c (
    .clk(clk), .resetn(resetn), .slow_clk(slow_clk_c), .slow_resetn(slow_rstn_c),
    .rise_pulse(rise_c), .fall_pulse(fall_c), .count(count_c)
  );

  int   checks   = 0;
  int   failures = 0;
  int   k        = 0;   // clk edges seen with resetn high since last release
  exp_t sb_q[$];

  int   tally_high = 0;
  int   tally_rise = 0;
  int   tally_fall = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input int inst,
                       input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s inst%0d k=%0d: got %0d expected %0d at %0t",
               name, inst, k, act, exp, $time);
    end
  endtask

  // Reference model: output state after k edges since reset release.
  //   count       = k mod 2^(S+1)
  //   slow_clk    = count in upper half of the period
  //   sync2 high  = k >= 2
  //   pulses      = sync2 and count one short of a slow_clk edge
  //   slow_resetn = counted falling edges >= H. A counted fall happens at an
  //                 edge j that is a multiple of the period with j >= 3, so
  //                 the count is floor(k/P) - floor(2/P).
  function automatic exp_t model(input int inst, input int kk, input logic rst_n,
                                 input bit tally);
    exp_t e;
    int s, h, p, half, cnt, counted;
    bit s2;
    case (inst)
      0:       begin s = 2; h = 2; end
      1:       begin s = 0; h = 1; end
      default: begin s = 4; h = 3; end
    endcase
    p        = 1 << (s + 1);
    half     = 1 << s;
    cnt      = kk % p;
    s2       = (kk >= 2);
    counted  = (kk / p) - (2 / p);
    e.inst   = inst;
    e.tally  = tally;
    if (!rst_n) begin
      e.count = '0; e.slow_clk = 1'b0; e.slow_resetn = 1'b0;
      e.rise  = 1'b0; e.fall = 1'b0;
    end else begin
      e.count       = 32'(cnt);
      e.slow_clk    = (cnt >= half);
      e.rise        = s2 && (cnt == half - 1);
      e.fall        = s2 && (cnt == p - 1);
      e.slow_resetn = (counted >= h);
    end
    return e;
  endfunction

  // Advance one clk cycle, optionally change resetn 2 time units after the
  // edge (asynchronously, well before the next edge), then queue the
  // expectations for the falling-edge sample.
  task automatic step(input logic next_rstn, input bit tally);
    @(posedge clk);
    if (resetn) k++;
    #2;
    if (next_rstn !== resetn) begin
      resetn = next_rstn;
      if (!resetn) k = 0;
    end
    for (int i = 0; i < 3; i++) sb_q.push_back(model(i, k, resetn, tally));
  endtask

  // Monitor: compares every queued expectation at the falling edge.
  initial begin
    exp_t e;
    logic [31:0] a_cnt;
    logic        a_clk, a_rstn, a_rise, a_fall;
    forever begin
      @(negedge clk);
      while (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        case (e.inst)
          0: begin a_cnt = 32'(count_a); a_clk = slow_clk_a; a_rstn = slow_rstn_a;
                   a_rise = rise_a; a_fall = fall_a; end
          1: begin a_cnt = 32'(count_b); a_clk = slow_clk_b; a_rstn = slow_rstn_b;
                   a_rise = rise_b; a_fall = fall_b; end
          default: begin a_cnt = 32'(count_c); a_clk = slow_clk_c; a_rstn = slow_rstn_c;
                   a_rise = rise_c; a_fall = fall_c; end
        endcase
        check("count",       e.inst, a_cnt,         e.count);
        check("slow_clk",    e.inst, 32'(a_clk),    32'(e.slow_clk));
        check("slow_resetn", e.inst, 32'(a_rstn),   32'(e.slow_resetn));
        check("rise_pulse",  e.inst, 32'(a_rise),   32'(e.rise));
        check("fall_pulse",  e.inst, 32'(a_fall),   32'(e.fall));
        if (e.tally && e.inst == 2) begin
          tally_high += int'(a_clk);
          tally_rise += int'(a_rise);
          tally_fall += int'(a_fall);
        end
      end
    end
  end

  // Watchdog: the stimulus is bounded, so reaching this means a hang.
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, k=%0d", k);
    $fatal(1, "watchdog expired");
  end

  initial begin
    resetn = 1'b0;

    // Reset held for a few cycles; outputs must sit at reset values.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0);

    // Release and run through the hold period of every instance.
    step(1'b1, 1'b0);
    while (!(k >= 20 && (k % 8) == 5)) step(1'b1, 1'b0);

    // Mid-run reset: the edge takes inst 0 to count 6 (slow_clk high), then
    // resetn drops between edges. The sample before the next edge must
    // already show zeros.
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    for (int i = 0; i < 30; i++) step(1'b1, 1'b0);

    // Random run lengths and reset bursts.
    for (int r = 0; r < 6; r++) begin
      int run_len, rst_len;
      run_len = $urandom_range(150, 5);
      rst_len = $urandom_range(3, 1);
      for (int i = 0; i < run_len; i++) step(1'b1, 1'b0);
      for (int i = 0; i < rst_len; i++) step(1'b0, 1'b0);
    end

    // Long run from a clean release: 1024 edges (32 periods of inst 2).
    step(1'b1, 1'b0);
    for (int i = 0; i < 1024; i++) step(1'b1, 1'b1);

    @(negedge clk);
    #1;
    check("sb_drain",  -1, 32'(sb_q.size()), 32'd0);
    check("long_high",  2, 32'(tally_high),  32'd512);
    check("long_rise",  2, 32'(tally_rise),  32'd32);
    check("long_fall",  2, 32'(tally_fall),  32'd32);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
